// File: rtl/bist_sequencer_if.sv
// Handshake bundle between the BIST controller and the sequencer.
// The controller (master) drives the run request and the MISR contents.
// The sequencer (slave) returns the datapath enables and the test status.
interface bist_sequencer_if #(
  parameter int SIG_WIDTH    = 16,
  parameter int NUM_PATTERNS = 2000
);
  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);

  logic                 bistmode;
  logic [SIG_WIDTH-1:0] misr_sig;
  logic                 cut_scanmode;
  logic                 lfsr_en;
  logic                 misr_en;
  logic                 misr_clear;
  logic                 bist_busy;
  logic [CNT_W-1:0]     pattern_cnt;
  logic                 bistdone;
  logic                 bistpass;

  modport master (
    output bistmode, misr_sig,
    input  cut_scanmode, lfsr_en, misr_en, misr_clear,
    input  bist_busy, pattern_cnt, bistdone, bistpass
  );

  modport slave (
    input  bistmode, misr_sig,
    output cut_scanmode, lfsr_en, misr_en, misr_clear,
    output bist_busy, pattern_cnt, bistdone, bistpass
  );
endinterface

// File: rtl/bist_sequencer.sv
// Scan-BIST sequencer: seeds the LFSR, shifts and captures NUM_PATTERNS
// patterns through the scan chains, unloads the last capture into the MISR,
// compares the signature and reports pass/fail.
// Every output comes straight from a flop: each output register is loaded
// from the decode of the next state, so it always matches the current state.
module bist_sequencer #(
  parameter int                   CHAIN_LEN    = 57,
  parameter int                   NUM_PATTERNS = 2000,
  parameter int                   SEED_CYCLES  = 16,
  parameter int                   SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 16'h5555
) (
  input logic             clk,
  input logic             rst,
  bist_sequencer_if.slave bus
);
  localparam int CNT_W   = $clog2(NUM_PATTERNS + 1);
  localparam int CYC_MAX = (SEED_CYCLES > CHAIN_LEN) ? SEED_CYCLES : CHAIN_LEN;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FLUSH   = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_r, state_nx;
  logic [CYC_W-1:0] cyc_r, cyc_nx;      // seed / shift cycle counter
  logic [CNT_W-1:0] pcnt_r, pcnt_nx;    // captures completed
  logic [CNT_W-1:0] pcnt_inc_s;
  logic             pass_r, pass_nx;

  logic scan_r, lfsr_r, men_r, clr_r, busy_r, done_r;
  logic scan_nx, lfsr_nx, men_nx, clr_nx, busy_nx, done_nx;

  // Saturating increment so pattern_cnt never wraps past NUM_PATTERNS.
  assign pcnt_inc_s = (pcnt_r == CNT_W'(NUM_PATTERNS)) ? pcnt_r : pcnt_r + CNT_W'(1);

  // Next-state, counter and pass-flag logic; abort overrides everything.
  always_comb begin
    state_nx = state_r;
    cyc_nx   = cyc_r;
    pcnt_nx  = pcnt_r;
    pass_nx  = pass_r;
    case (state_r)
      IDLE: begin
        if (bus.bistmode) begin
          state_nx = SEED;
          cyc_nx   = CYC_W'(0);
          pcnt_nx  = CNT_W'(0);
          pass_nx  = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      SEED: begin
        if (cyc_r == CYC_W'(SEED_CYCLES - 1)) begin
          state_nx = SHIFT;
          cyc_nx   = CYC_W'(0);
        end else begin
          cyc_nx = cyc_r + CYC_W'(1);
        end
      end
      SHIFT: begin
        if (cyc_r == CYC_W'(CHAIN_LEN - 1)) begin
          state_nx = CAPTURE;
          cyc_nx   = CYC_W'(0);
        end else begin
          cyc_nx = cyc_r + CYC_W'(1);
        end
      end
      CAPTURE: begin
        pcnt_nx = pcnt_inc_s;
        cyc_nx  = CYC_W'(0);
        if (pcnt_inc_s == CNT_W'(NUM_PATTERNS)) begin
          state_nx = FLUSH;
        end else begin
          state_nx = SHIFT;
        end
      end
      FLUSH: begin
        if (cyc_r == CYC_W'(CHAIN_LEN - 1)) begin
          state_nx = COMPARE;
          cyc_nx   = CYC_W'(0);
        end else begin
          cyc_nx = cyc_r + CYC_W'(1);
        end
      end
      COMPARE: begin
        // misr_sig here already includes the last FLUSH shift.
        pass_nx  = (bus.misr_sig == GOLDEN_SIG);
        state_nx = DONE;
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Dropping bistmode anywhere outside IDLE abandons the run without a result.
    if (!bus.bistmode && (state_r != IDLE)) begin
      state_nx = IDLE;
      cyc_nx   = CYC_W'(0);
      pcnt_nx  = CNT_W'(0);
      pass_nx  = 1'b0;
    end else begin
      pass_nx = pass_nx;
    end
  end

  // Output decode of the upcoming state, loaded into the output flops.
  always_comb begin
    scan_nx = 1'b0;
    lfsr_nx = 1'b0;
    men_nx  = 1'b0;
    clr_nx  = 1'b0;
    done_nx = 1'b0;
    busy_nx = (state_nx != IDLE) && (state_nx != DONE);
    case (state_nx)
      SEED: begin
        lfsr_nx = 1'b1;
        clr_nx  = 1'b1;
      end
      SHIFT: begin
        scan_nx = 1'b1;
        lfsr_nx = 1'b1;
        // Nothing valid is in the chains before the first capture.
        men_nx  = (pcnt_nx != CNT_W'(0));
      end
      FLUSH: begin
        scan_nx = 1'b1;
        lfsr_nx = 1'b1;
        men_nx  = 1'b1;
      end
      DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        done_nx = 1'b0;
      end
    endcase
  end

  // State, counters and output flops; reset forces everything to zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cyc_r   <= CYC_W'(0);
      pcnt_r  <= CNT_W'(0);
      pass_r  <= 1'b0;
      scan_r  <= 1'b0;
      lfsr_r  <= 1'b0;
      men_r   <= 1'b0;
      clr_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cyc_r   <= cyc_nx;
      pcnt_r  <= pcnt_nx;
      pass_r  <= pass_nx;
      scan_r  <= scan_nx;
      lfsr_r  <= lfsr_nx;
      men_r   <= men_nx;
      clr_r   <= clr_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
    end
  end

  assign bus.cut_scanmode = scan_r;
  assign bus.lfsr_en      = lfsr_r;
  assign bus.misr_en      = men_r;
  assign bus.misr_clear   = clr_r;
  assign bus.bist_busy    = busy_r;
  assign bus.pattern_cnt  = pcnt_r;
  assign bus.bistdone     = done_r;
  assign bus.bistpass     = pass_r;
endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: a per-cycle vector table for full runs
// (CHAIN_LEN=4, NUM_PATTERNS=3, SEED_CYCLES=2), hand sequences for abort and
// mid-run reset, and a longer-chain instance for end-to-end latency.
module tb_bist_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bist_sequencer_if #(.SIG_WIDTH(16), .NUM_PATTERNS(3))  bus ();
  bist_sequencer_if #(.SIG_WIDTH(16), .NUM_PATTERNS(20)) bus2 ();

  bist_sequencer #(
    .CHAIN_LEN(4), .NUM_PATTERNS(3), .SEED_CYCLES(2), .SIG_WIDTH(16), .GOLDEN_SIG(16'h5555)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  bist_sequencer #(
    .CHAIN_LEN(57), .NUM_PATTERNS(20), .SEED_CYCLES(16), .SIG_WIDTH(16), .GOLDEN_SIG(16'h5555)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // exp = {scanmode, lfsr_en, misr_en, misr_clear, busy, done, pass, pattern_cnt[1:0]}
  typedef struct {
    logic        bm;
    logic [15:0] misr;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   n_scan, n_lfsr, n_men, n_clr, first_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.cut_scanmode, bus.lfsr_en, bus.misr_en, bus.misr_clear,
            bus.bist_busy, bus.bistdone, bus.bistpass, bus.pattern_cnt};
  endfunction

  task automatic add(input int n, input logic bm, input logic [15:0] misr, input logic [8:0] e);
    vec_t v;
    v.bm = bm; v.misr = misr; v.exp = e;
    repeat (n) tbl.push_back(v);
  endtask

  // One complete run from IDLE, two DONE cycles, then release back to IDLE.
  task automatic build_run(input logic [15:0] misr, input logic pass);
    tbl.delete();
    add(2, 1'b1, misr, {4'b0101, 1'b1, 1'b0, 1'b0, 2'd0});  // SEED
    add(4, 1'b1, misr, {4'b1100, 1'b1, 1'b0, 1'b0, 2'd0});  // SHIFT 1
    add(1, 1'b1, misr, {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});  // CAPTURE 1
    add(4, 1'b1, misr, {4'b1110, 1'b1, 1'b0, 1'b0, 2'd1});  // SHIFT 2
    add(1, 1'b1, misr, {4'b0000, 1'b1, 1'b0, 1'b0, 2'd1});  // CAPTURE 2
    add(4, 1'b1, misr, {4'b1110, 1'b1, 1'b0, 1'b0, 2'd2});  // SHIFT 3
    add(1, 1'b1, misr, {4'b0000, 1'b1, 1'b0, 1'b0, 2'd2});  // CAPTURE 3
    add(4, 1'b1, misr, {4'b1110, 1'b1, 1'b0, 1'b0, 2'd3});  // FLUSH
    add(1, 1'b1, misr, {4'b0000, 1'b1, 1'b0, 1'b0, 2'd3});  // COMPARE
    add(2, 1'b1, misr, {4'b0000, 1'b0, 1'b1, pass, 2'd3});  // DONE
    add(1, 1'b0, misr, {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0});  // back to IDLE
  endtask

  // Drive each record at a falling edge, check outputs at the next falling edge.
  task automatic run_table(input string name, input int start, input int n);
    logic [8:0] act;
    n_scan = 0; n_lfsr = 0; n_men = 0; n_clr = 0; first_done = -1;
    for (int i = start; i < start + n; i++) begin
      bus.bistmode = tbl[i].bm;
      bus.misr_sig = tbl[i].misr;
      @(negedge clk);
      act = outs();
      n_scan += int'(act[8]);
      n_lfsr += int'(act[7]);
      n_men  += int'(act[6]);
      n_clr  += int'(act[5]);
      if (act[3] && first_done < 0) first_done = i;
      check($sformatf("%s[%0d]", name, i), 32'(act), 32'(tbl[i].exp));
    end
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.bistmode  = 1'b0;
    bus.misr_sig  = 16'h0000;
    bus2.bistmode = 1'b0;
    bus2.misr_sig = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // Idle with bistmode low: nothing moves.
    tbl.delete();
    add(10, 1'b0, 16'h0000, 9'd0);
    run_table("idle", 0, 10);

    // Golden run: per-cycle waveform plus enable tallies and latency.
    build_run(16'h5555, 1'b1);
    run_table("pass_run", 0, 25);
    check("scanmode_cycles", 32'(n_scan), 32'd16);
    check("lfsr_cycles", 32'(n_lfsr), 32'd18);
    check("misr_en_cycles", 32'(n_men), 32'd12);
    check("misr_clear_cycles", 32'(n_clr), 32'd2);
    check("done_latency", 32'(first_done), 32'd22);

    // Signature off by one bit: done but fail.
    build_run(16'h5554, 1'b0);
    run_table("fail_run", 0, 25);
    check("fail_done_latency", 32'(first_done), 32'd22);

    // Abort during the second SHIFT, then a full rerun.
    build_run(16'h5555, 1'b1);
    run_table("abort_pre", 0, 9);
    bus.bistmode = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    check("abort_idle", 32'(outs()), 32'd0);
    run_table("after_abort", 0, 25);
    check("rerun_latency", 32'(first_done), 32'd22);

    // Asynchronous reset during FLUSH: outputs clear before any clock edge.
    run_table("rst_pre", 0, 19);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    check("rst_held_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    run_table("after_rst", 0, 25);
    check("after_rst_latency", 32'(first_done), 32'd22);

    // Long chain, 20 patterns: latency 16 + 20*58 + 57 + 1 = 1234.
    bus2.bistmode = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.bistdone && n < 3000);
    check("long_latency", 32'(n - 1), 32'd1234);
    check("long_pass", 32'(bus2.bistpass), 32'd1);
    check("long_pattern_cnt", 32'(bus2.pattern_cnt), 32'd20);
    bus2.bistmode = 1'b0;
    @(negedge clk);
    check("long_release", 32'({bus2.bistdone, bus2.bistpass, bus2.bist_busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
